// File: rtl/irq_ctrl_n_if.sv
// Bus bundle between the interrupt controller and its host: mmapper register
// port, raw interrupt lines and the CPU eip/eip_reply handshake.
interface irq_ctrl_n_if #(
    parameter int unsigned NUM_SRC = 8
);
    logic [NUM_SRC-1:0] irq_src;
    logic [2:0]         a;
    logic [31:0]        d;
    logic               we;
    logic [31:0]        spo;
    logic               interrupt;
    logic               int_istimer;
    logic               int_reply;
    logic [4:0]         int_id;

    modport master (
        output irq_src, a, d, we, int_reply,
        input  spo, interrupt, int_istimer, int_id
    );

    modport slave (
        input  irq_src, a, d, we, int_reply,
        output spo, interrupt, int_istimer, int_id
    );
endinterface

// File: rtl/irq_ctrl_n.sv
// Parametrised interrupt controller: edge/level capture, enable masks, fixed
// priority (source 0 highest) and a one-at-a-time request/claim/complete flow.
module irq_ctrl_n #(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned TIMER_SRC = 0,
    parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF
) (
    input logic         clk,
    input logic         rst_n,
    irq_ctrl_n_if.slave bus
);
    localparam int unsigned ID_W = 5;
    localparam logic [NUM_SRC-1:0] EDGE_M = EDGE_MASK[NUM_SRC-1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_id, w_id_nxt, w_win;
    logic               r_irq, r_istimer, r_gen;
    logic [NUM_SRC-1:0] r_prev, r_pend, r_en, r_ovr;
    logic [NUM_SRC-1:0] w_rise, w_cand, w_id_hot, w_reply_clr, w_d_src;
    logic [NUM_SRC-1:0] w_pend_clr, w_ovr_clr, w_pend_nxt, w_ovr_nxt;
    logic               w_wr_pend, w_wr_en, w_wr_gen, w_wr_cmpl, w_wr_ovr;
    logic [31:0]        w_spo;
    logic               w_unused_d;

    assign w_d_src    = bus.d[NUM_SRC-1:0];
    assign w_unused_d = ^bus.d;
    assign w_wr_pend  = bus.we && (bus.a == 3'd0);
    assign w_wr_en    = bus.we && (bus.a == 3'd1);
    assign w_wr_gen   = bus.we && (bus.a == 3'd2);
    assign w_wr_cmpl  = bus.we && (bus.a == 3'd4);
    assign w_wr_ovr   = bus.we && (bus.a == 3'd5);

    assign w_rise = bus.irq_src & ~r_prev;
    assign w_cand = r_gen ? (r_pend & r_en) : '0;

    // Lowest-index candidate wins
    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win = ID_W'(i);
        end
    end

    always_comb begin
        w_id_hot = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_id_hot[i] = (r_id == ID_W'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_reply_clr = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_cand) begin
                    w_state_nxt = ST_ASSERT;
                    w_id_nxt    = w_win;
                end
            end
            ST_ASSERT: begin
                if (bus.int_reply) begin
                    w_state_nxt = ST_SERVICE;
                    w_reply_clr = w_id_hot;
                end else if (!(|(w_cand & w_id_hot))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_wr_cmpl && (bus.d[ID_W-1:0] == r_id)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_irq     <= 1'b0;
            r_istimer <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_irq     <= (w_state_nxt == ST_ASSERT);
            r_istimer <= (w_state_nxt == ST_ASSERT) && (w_id_nxt == ID_W'(TIMER_SRC));
        end
    end

    // New edges win over any same-cycle clear; level sources just follow the line
    assign w_pend_clr = (w_wr_pend ? w_d_src : '0) | w_reply_clr;
    assign w_ovr_clr  = w_wr_ovr ? w_d_src : '0;
    assign w_pend_nxt = (EDGE_M & ((r_pend & ~w_pend_clr) | w_rise)) | (~EDGE_M & bus.irq_src);
    assign w_ovr_nxt  = EDGE_M & ((r_ovr & ~w_ovr_clr) | (w_rise & r_pend));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_ovr  <= '0;
            r_en   <= '0;
            r_gen  <= 1'b0;
        end else begin
            r_prev <= bus.irq_src;
            r_pend <= w_pend_nxt;
            r_ovr  <= w_ovr_nxt;
            if (w_wr_en)  r_en  <= w_d_src;
            if (w_wr_gen) r_gen <= bus.d[0];
        end
    end

    always_comb begin
        w_spo = '0;
        case (bus.a)
            3'd0:    w_spo = 32'(r_pend);
            3'd1:    w_spo = 32'(r_en);
            3'd2:    w_spo = {31'b0, r_gen};
            3'd3:    w_spo = {(r_state == ST_SERVICE), 26'b0, r_id};
            3'd5:    w_spo = 32'(r_ovr);
            3'd6:    w_spo = 32'(r_state);
            3'd7:    w_spo = 32'(NUM_SRC);
            default: w_spo = '0;
        endcase
    end

    assign bus.spo         = w_spo;
    assign bus.interrupt   = r_irq;
    assign bus.int_istimer = r_istimer;
    assign bus.int_id      = r_id;
endmodule

// File: tb/tb_irq_ctrl_n.sv
// Bench for irq_ctrl_n: directed vector table, async-reset sequence, then
// random traffic against a per-source behavioural model.
module tb_irq_ctrl_n;
    localparam int unsigned NUM = 8;
    localparam int unsigned TMR = 0;
    localparam logic [31:0] EM  = 32'hFFFF_FFF7;

    logic clk = 1'b0;
    logic rst_n;

    irq_ctrl_n_if #(.NUM_SRC(NUM)) bus();
    irq_ctrl_n #(.NUM_SRC(NUM), .TIMER_SRC(TMR), .EDGE_MASK(EM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  src;
        logic [2:0]  a;
        logic [31:0] d;
        logic        we;
        logic        rep;
        logic        e_irq;
        logic        e_tim;
        logic [4:0]  e_id;
        logic [31:0] e_spo;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    bit m_pend[NUM];
    bit m_en[NUM];
    bit m_ovr[NUM];
    bit m_prev[NUM];
    bit m_gen;
    int m_state;
    int m_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic irq, input logic tim,
                           input logic [4:0] id, input logic [31:0] spo);
        chk($sformatf("%s interrupt", tag), 32'(bus.interrupt), 32'(irq));
        chk($sformatf("%s int_istimer", tag), 32'(bus.int_istimer), 32'(tim));
        chk($sformatf("%s int_id", tag), 32'(bus.int_id), 32'(id));
        chk($sformatf("%s spo a=%0d", tag, bus.a), bus.spo, spo);
    endtask

    task automatic drive(input logic [7:0] src, input logic [2:0] a, input logic [31:0] d,
                         input logic we, input logic rep);
        bus.irq_src   = src;
        bus.a         = a;
        bus.d         = d;
        bus.we        = we;
        bus.int_reply = rep;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic [7:0] src, input logic [2:0] a, input logic [31:0] d,
                               input logic we, input logic rep, input logic irq, input logic tim,
                               input logic [4:0] id, input logic [31:0] spo);
        vec_t r;
        r.src = src; r.a = a; r.d = d; r.we = we; r.rep = rep;
        r.e_irq = irq; r.e_tim = tim; r.e_id = id; r.e_spo = spo;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
        end
        m_gen = 0; m_state = 0; m_id = 0;
    endtask

    function automatic bit m_cand(input int i);
        return m_pend[i] && m_en[i] && m_gen;
    endfunction

    // One clock of the controller's rules, applied to the inputs of that cycle
    task automatic model_step(input logic [7:0] src, input logic [2:0] a, input logic [31:0] d,
                              input logic we, input logic rep);
        int win = -1;
        int rep_clr = -1;
        int ns = m_state;
        int nid = m_id;
        for (int i = 0; i < NUM; i++) if (m_cand(i) && win < 0) win = i;
        if (m_state == 0) begin
            if (win >= 0) begin ns = 1; nid = win; end
        end else if (m_state == 1) begin
            if (rep) begin ns = 2; rep_clr = m_id; end
            else if (!m_cand(m_id)) ns = 0;
        end else begin
            if (we && a == 3'd4 && int'(d[4:0]) == m_id) ns = 0;
        end
        for (int i = 0; i < NUM; i++) begin
            bit rise = src[i] && !m_prev[i];
            if (EM[i]) begin
                if (rise && m_pend[i]) m_ovr[i] = 1;
                else if (we && a == 3'd5 && d[i]) m_ovr[i] = 0;
                if (rise) m_pend[i] = 1;
                else if ((we && a == 3'd0 && d[i]) || rep_clr == i) m_pend[i] = 0;
            end else begin
                m_pend[i] = src[i];
            end
            m_prev[i] = src[i];
            if (we && a == 3'd1) m_en[i] = d[i];
        end
        if (we && a == 3'd2) m_gen = d[0];
        m_state = ns;
        m_id = nid;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r = '0;
        case (a)
            3'd0: for (int i = 0; i < NUM; i++) r[i] = m_pend[i];
            3'd1: for (int i = 0; i < NUM; i++) r[i] = m_en[i];
            3'd2: r[0] = m_gen;
            3'd3: begin r[31] = (m_state == 2); r[4:0] = 5'(m_id); end
            3'd5: for (int i = 0; i < NUM; i++) r[i] = m_ovr[i];
            3'd6: r = 32'(m_state);
            3'd7: r = 32'(NUM);
            default: r = '0;
        endcase
        return r;
    endfunction

    initial begin
        logic [7:0]  src;
        logic [2:0]  a;
        logic [31:0] d;
        logic        we, rep, e_irq, e_tim;

        rst_n = 1'b0;
        drive(8'h00, 3'd0, 32'h0, 1'b0, 1'b0);
        step();
        chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        rst_n = 1'b1;

        // src, a, d, we, rep | irq, tim, id, spo
        tbl.push_back(v(8'h00, 3'd1, 32'h5, 1, 0, 0, 0, 5'd0, 32'h5));
        tbl.push_back(v(8'h00, 3'd2, 32'h1, 1, 0, 0, 0, 5'd0, 32'h1));
        tbl.push_back(v(8'h04, 3'd0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h4));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 1, 0, 5'd2, 32'h4));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 1, 0, 0, 5'd2, 32'h2));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 0, 0, 5'd2, 32'h0));
        tbl.push_back(v(8'h00, 3'd3, 32'h0, 0, 0, 0, 0, 5'd2, 32'h8000_0002));
        tbl.push_back(v(8'h00, 3'd4, 32'h2, 1, 0, 0, 0, 5'd2, 32'h0));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 0, 0, 0, 5'd2, 32'h0));
        tbl.push_back(v(8'h05, 3'd0, 32'h0, 0, 0, 0, 0, 5'd2, 32'h5));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 1, 1, 5'd0, 32'h5));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 1, 0, 0, 5'd0, 32'h2));
        tbl.push_back(v(8'h00, 3'd4, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 1, 0, 5'd2, 32'h4));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 1, 0, 0, 5'd2, 32'h0));
        tbl.push_back(v(8'h00, 3'd4, 32'h2, 1, 0, 0, 0, 5'd2, 32'h0));
        tbl.push_back(v(8'h00, 3'd1, 32'h7, 1, 0, 0, 0, 5'd2, 32'h7));
        tbl.push_back(v(8'h02, 3'd0, 32'h0, 0, 0, 0, 0, 5'd2, 32'h2));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 1, 0, 5'd1, 32'h2));
        tbl.push_back(v(8'h02, 3'd5, 32'h0, 0, 0, 1, 0, 5'd1, 32'h2));
        tbl.push_back(v(8'h00, 3'd5, 32'h2, 1, 0, 1, 0, 5'd1, 32'h0));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 1, 0, 0, 5'd1, 32'h2));
        tbl.push_back(v(8'h02, 3'd0, 32'h2, 1, 0, 0, 0, 5'd1, 32'h2));
        tbl.push_back(v(8'h00, 3'd5, 32'h0, 0, 0, 0, 0, 5'd1, 32'h0));
        tbl.push_back(v(8'h00, 3'd4, 32'h1, 1, 0, 0, 0, 5'd1, 32'h0));
        tbl.push_back(v(8'h00, 3'd0, 32'h0, 0, 0, 1, 0, 5'd1, 32'h2));
        tbl.push_back(v(8'h00, 3'd0, 32'h2, 1, 0, 1, 0, 5'd1, 32'h0));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 0, 0, 0, 5'd1, 32'h0));
        tbl.push_back(v(8'h00, 3'd1, 32'h8, 1, 0, 0, 0, 5'd1, 32'h8));
        tbl.push_back(v(8'h08, 3'd0, 32'h0, 0, 0, 0, 0, 5'd1, 32'h8));
        tbl.push_back(v(8'h08, 3'd0, 32'h0, 0, 0, 1, 0, 5'd3, 32'h8));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 0, 1, 0, 5'd3, 32'h1));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 0, 0, 0, 5'd3, 32'h0));
        tbl.push_back(v(8'h08, 3'd0, 32'h0, 0, 0, 0, 0, 5'd3, 32'h8));
        tbl.push_back(v(8'h08, 3'd0, 32'h0, 0, 0, 1, 0, 5'd3, 32'h8));
        tbl.push_back(v(8'h08, 3'd6, 32'h0, 0, 1, 0, 0, 5'd3, 32'h2));
        tbl.push_back(v(8'h08, 3'd4, 32'h5, 1, 0, 0, 0, 5'd3, 32'h0));
        tbl.push_back(v(8'h08, 3'd6, 32'h0, 0, 0, 0, 0, 5'd3, 32'h2));
        tbl.push_back(v(8'h08, 3'd4, 32'h3, 1, 0, 0, 0, 5'd3, 32'h0));
        tbl.push_back(v(8'h00, 3'd6, 32'h0, 0, 0, 1, 0, 5'd3, 32'h1));
        tbl.push_back(v(8'h00, 3'd7, 32'h0, 0, 0, 0, 0, 5'd3, 32'h8));

        foreach (tbl[k]) begin
            drive(tbl[k].src, tbl[k].a, tbl[k].d, tbl[k].we, tbl[k].rep);
            step();
            chk_out($sformatf("row%0d", k), tbl[k].e_irq, tbl[k].e_tim, tbl[k].e_id, tbl[k].e_spo);
        end

        // Async reset while a level request is being presented
        drive(8'h08, 3'd0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst pre interrupt", 32'(bus.interrupt), 32'd1);
        #2 rst_n = 1'b0;
        drive(8'h00, 3'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst async interrupt", 32'(bus.interrupt), 32'd0);
        chk("rst async int_id", 32'(bus.int_id), 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        bus.a = 3'd1; #1 chk("rst ENABLE", bus.spo, 32'h0);
        bus.a = 3'd0; #1 chk("rst PENDING", bus.spo, 32'h0);
        bus.a = 3'd6; #1 chk("rst STATE", bus.spo, 32'h0);
        bus.a = 3'd7; #1 chk("rst NUM", bus.spo, 32'h8);
        chk("rst interrupt", 32'(bus.interrupt), 32'd0);

        // Random traffic against the model
        model_reset();
        src = 8'h00;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) src = 8'($urandom & $urandom);
            a   = 3'($urandom_range(0, 7));
            we  = ($urandom_range(0, 3) == 0);
            rep = ($urandom_range(0, 3) == 0);
            d   = $urandom;
            if (a == 3'd4) d[4:0] = 5'($urandom_range(0, 8));
            if (a == 3'd2) d[0] = ($urandom_range(0, 3) != 0);
            drive(src, a, d, we, rep);
            model_step(src, a, d, we, rep);
            step();
            e_irq = (m_state == 1);
            e_tim = e_irq && (m_id == int'(TMR));
            chk_out($sformatf("rnd%0d", c), e_irq, e_tim, 5'(m_id), m_read(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
